// File: rtl/mem_req_serializer.sv
// MEM-stage serializer: issues up to two load/store slots (slot0 first) over a req/gnt + rvalid bus,
// aligns load data, reports misalignment precisely and holds the pipeline until the bundle completes.
module mem_req_serializer #(
  parameter int ADDR_W     = 32,
  parameter int WAIT_LIMIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_stall,
  input  logic              flash,
  input  logic [1:0]        in_valid,
  input  logic [1:0]        in_we,
  input  logic [ADDR_W-1:0] in_addr0,
  input  logic [ADDR_W-1:0] in_addr1,
  input  logic [31:0]       in_wdata0,
  input  logic [31:0]       in_wdata1,
  input  logic [1:0]        in_size0,
  input  logic [1:0]        in_size1,
  input  logic              in_sext0,
  input  logic              in_sext1,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  output logic              stall_req,
  output logic [1:0]        res_valid,
  output logic [31:0]       res_rdata0,
  output logic [31:0]       res_rdata1,
  output logic [1:0]        exc,
  output logic [ADDR_W-1:0] exc_bad_addr,
  output logic              bus_err
);

  // Handshake: bus_req stays high with stable fields until bus_gnt is sampled high on a rising
  // edge; for a granted load exactly one bus_rvalid follows at least one cycle later.
  localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              cur_q, cur_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        vld_q, vld_d;
  logic [1:0]        exc_q, exc_d;
  logic [31:0]       rd0_q, rd0_d, rd1_q, rd1_d;
  logic [ADDR_W-1:0] bad_q, bad_d;

  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  logic [1:0]        c_size;
  logic              c_sext, c_we;
  logic [1:0]        a_lo;
  logic              mis0, mis1, timeout, slot_done;
  logic [31:0]       shifted, load_data, slot_data;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return ((size == 2'd1) && a[0]) || (size[1] && (a != 2'd0));
  endfunction

  assign c_addr  = cur_q ? in_addr1  : in_addr0;
  assign c_wdata = cur_q ? in_wdata1 : in_wdata0;
  assign c_size  = cur_q ? in_size1  : in_size0;
  assign c_sext  = cur_q ? in_sext1  : in_sext0;
  assign c_we    = cur_q ? in_we[1]  : in_we[0];
  assign a_lo    = c_addr[1:0];

  assign mis0    = misaligned(in_size0, in_addr0[1:0]);
  assign mis1    = misaligned(in_size1, in_addr1[1:0]);
  assign timeout = (WAIT_LIMIT != 0) && (cnt_q == CNT_W'(WAIT_LIMIT - 1));

  assign shifted = bus_rdata >> {a_lo, 3'b000};

  always_comb begin
    case (c_size)
      2'd0:    load_data = {{24{c_sext & shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = {{16{c_sext & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  assign bus_req  = (state_q == REQ);
  assign bus_we   = c_we;
  assign bus_addr = c_addr;

  always_comb begin
    case (c_size)
      2'd0: begin
        bus_be    = 4'b0001 << a_lo;
        bus_wdata = {4{c_wdata[7:0]}};
      end
      2'd1: begin
        bus_be    = 4'b0011 << a_lo;
        bus_wdata = {2{c_wdata[15:0]}};
      end
      default: begin
        bus_be    = 4'hF;
        bus_wdata = c_wdata;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    cnt_d     = '0;
    vld_d     = vld_q;
    exc_d     = exc_q;
    rd0_d     = rd0_q;
    rd1_d     = rd1_q;
    bad_d     = bad_q;
    stall_req = 1'b0;
    bus_err   = 1'b0;
    slot_done = 1'b0;
    slot_data = 32'h0;
    case (state_q)
      IDLE: begin
        stall_req = (|in_valid) & ~flash;
        if (stall_req) begin
          cur_d = ~in_valid[0];
          if (in_valid[0] ? mis0 : mis1) begin
            exc_d   = in_valid[0] ? 2'b01 : 2'b10;
            bad_d   = in_valid[0] ? in_addr0 : in_addr1;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall_req = ~flash;
        if (bus_gnt) begin
          if (c_we) begin
            if (flash) state_d = IDLE;
            else       slot_done = 1'b1;
          end else begin
            state_d = flash ? DRAIN : WAIT;
          end
        end else if (flash) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        stall_req = ~flash;
        cnt_d     = cnt_q + CNT_W'(1);
        if (bus_rvalid || timeout) begin
          bus_err = ~bus_rvalid;
          if (flash) begin
            state_d = IDLE;
          end else begin
            slot_done = 1'b1;
            slot_data = bus_rvalid ? load_data : 32'h0;
          end
        end else if (flash) begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        if (!pipe_stall) state_d = IDLE;
      end
      DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_rvalid || timeout) begin
          bus_err = ~bus_rvalid;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Completion of the current slot: record it, then move on to slot1 or finish.
    if (slot_done) begin
      vld_d[cur_q] = 1'b1;
      if (cur_q) rd1_d = slot_data;
      else       rd0_d = slot_data;
      if (!cur_q && in_valid[1]) begin
        cur_d = 1'b1;
        if (mis1) begin
          exc_d[1] = 1'b1;
          bad_d    = in_addr1;
          state_d  = DONE;
        end else begin
          state_d = REQ;
        end
      end else begin
        state_d = DONE;
      end
    end

    if (state_d == IDLE || state_d == DRAIN) begin
      vld_d = '0;
      exc_d = '0;
      rd0_d = '0;
      rd1_d = '0;
      bad_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= 1'b0;
      cnt_q   <= '0;
      vld_q   <= '0;
      exc_q   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      exc_q   <= exc_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      bad_q   <= bad_d;
    end
  end

  assign res_valid    = (state_q == DONE) ? vld_q : 2'b00;
  assign res_rdata0   = rd0_q;
  assign res_rdata1   = rd1_q;
  assign exc          = exc_q;
  assign exc_bad_addr = bad_q;

endmodule
